// File: rtl/calc_display.sv
// Display back end: captures the calculator's digit stream into a double-buffered
// frame and scans it onto an active-low multiplexed seven-segment display.
module calc_display #(
    parameter int DIGITS      = 8,
    parameter int REFRESH_DIV = 50000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [1:0]        status,
    input  logic [3:0]        data,
    input  logic [3:0]        pos,
    output logic [DIGITS-1:0] an,
    output logic [6:0]        seg,
    output logic              frame_done
);

    localparam int DIV_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (DIGITS > 2) ? $clog2(DIGITS) : 1;

    localparam logic [1:0] ST_ERR   = 2'b00;
    localparam logic [1:0] ST_BUSY  = 2'b01;
    localparam logic [1:0] ST_READY = 2'b10;
    localparam logic [1:0] ST_PRINT = 2'b11;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_ZERO  = 7'b1000000;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_R     = 7'b0101111;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_ERROR   = 2'd2
    } state_e;

    typedef logic [DIGITS-1:0][3:0] frame_t;

    state_e             state_q, state_d;
    frame_t             shadow_q, shadow_d;
    frame_t             disp_q, disp_d;
    logic               err_q, err_d;
    logic               frame_done_q, frame_done_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [DIGITS-1:0]  an_q, an_d;
    logic [6:0]         seg_q, seg_d;
    logic               wr_s;
    logic               wrap_s;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // Slot 0 is never blanked; anything above the highest non-zero slot is.
    function automatic logic [6:0] slot_seg(input int slot, input frame_t fb, input logic err);
        int         top;
        logic [6:0] s;
        top = 0;
        for (int i = 0; i < DIGITS; i++) begin
            if (fb[i] != 4'd0) begin
                top = i;
            end
        end
        if (err) begin
            if (slot == 2) begin
                s = SEG_E;
            end else if (slot < 2) begin
                s = SEG_R;
            end else begin
                s = SEG_BLANK;
            end
        end else if (slot > top) begin
            s = SEG_BLANK;
        end else begin
            s = bcd_to_seg(fb[slot]);
        end
        return s;
    endfunction

    assign wr_s = (status == ST_PRINT) && (pos != 4'd0) && (int'(pos) <= DIGITS);

    // Receiver FSM next state, shadow writes and commit into the display buffer.
    always_comb begin
        state_d      = state_q;
        shadow_d     = shadow_q;
        disp_d       = disp_q;
        err_d        = err_q;
        frame_done_d = 1'b0;
        case (state_q)
            S_IDLE, S_ERROR: begin
                if (status == ST_PRINT) begin
                    state_d  = S_CAPTURE;
                    shadow_d = '0;
                    for (int i = 0; i < DIGITS; i++) begin
                        if (wr_s && (pos == 4'(i + 1))) begin
                            shadow_d[i] = data;
                        end else begin
                            shadow_d[i] = 4'd0;
                        end
                    end
                end else if (status == ST_ERR) begin
                    state_d = S_ERROR;
                    err_d   = 1'b1;
                end else begin
                    state_d = state_q;
                end
            end
            S_CAPTURE: begin
                if (status == ST_READY) begin
                    state_d      = S_IDLE;
                    disp_d       = shadow_q;
                    err_d        = 1'b0;
                    frame_done_d = 1'b1;
                end else if (status == ST_ERR) begin
                    state_d = S_ERROR;
                    err_d   = 1'b1;
                end else begin
                    for (int i = 0; i < DIGITS; i++) begin
                        if (wr_s && (pos == 4'(i + 1))) begin
                            shadow_d[i] = data;
                        end else begin
                            shadow_d[i] = shadow_q[i];
                        end
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Scanner: the outputs reload only when the index moves, using the
    // post-commit buffer so a coinciding commit is shown immediately.
    always_comb begin
        wrap_s = (div_q == DIV_W'(REFRESH_DIV - 1));
        div_d  = div_q + {{(DIV_W-1){1'b0}}, 1'b1};
        idx_d  = idx_q;
        an_d   = an_q;
        seg_d  = seg_q;
        if (wrap_s) begin
            div_d = '0;
            if (idx_q == IDX_W'(DIGITS - 1)) begin
                idx_d = '0;
            end else begin
                idx_d = idx_q + {{(IDX_W-1){1'b0}}, 1'b1};
            end
            an_d  = ~({{(DIGITS-1){1'b0}}, 1'b1} << idx_d);
            seg_d = slot_seg(int'(idx_d), disp_d, err_d);
        end else begin
            idx_d = idx_q;
        end
    end

    // State register for receiver, buffers, scanner and registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            shadow_q     <= '0;
            disp_q       <= '0;
            err_q        <= 1'b0;
            frame_done_q <= 1'b0;
            div_q        <= '0;
            idx_q        <= '0;
            an_q         <= {{(DIGITS-1){1'b1}}, 1'b0};
            seg_q        <= SEG_ZERO;
        end else begin
            state_q      <= state_d;
            shadow_q     <= shadow_d;
            disp_q       <= disp_d;
            err_q        <= err_d;
            frame_done_q <= frame_done_d;
            div_q        <= div_d;
            idx_q        <= idx_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_calc_display.sv
// Directed bench for calc_display: one instance scanning every 4 cycles for
// frame contents, one every 2 cycles for scan timing, both on the same stimulus.
module tb_calc_display;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] status = 2'b01;
    logic [3:0] data = 4'd0;
    logic [3:0] pos = 4'd0;
    logic [7:0] an4, an2;
    logic [6:0] seg4, seg2;
    logic       fd4, fd2;

    int         n_checks = 0;
    int         n_fail = 0;
    int         fd_cnt = 0;
    int         fd_double = 0;
    logic       fd_prev = 1'b0;
    logic [6:0] seen [8];

    calc_display #(.DIGITS(8), .REFRESH_DIV(4)) u_dut4 (
        .clock(clock), .reset(reset), .status(status), .data(data), .pos(pos),
        .an(an4), .seg(seg4), .frame_done(fd4)
    );

    calc_display #(.DIGITS(8), .REFRESH_DIV(2)) u_dut2 (
        .clock(clock), .reset(reset), .status(status), .data(data), .pos(pos),
        .an(an2), .seg(seg2), .frame_done(fd2)
    );

    always #5 clock = ~clock;

    // frame_done pulse counter for the 4-cycle instance
    always @(negedge clock) begin
        if (fd4) fd_cnt++;
        if (fd4 && fd_prev) fd_double++;
        fd_prev = fd4;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [1:0] st, input logic [3:0] p, input logic [3:0] d);
        status = st;
        pos    = p;
        data   = d;
        @(posedge clock);
        #1;
    endtask

    task automatic commit_frame(input string tag);
        int base;
        base   = fd_cnt;
        status = 2'b10;
        pos    = 4'd0;
        data   = 4'd0;
        @(posedge clock);
        @(negedge clock);
        chk({tag, "_fd_hi"}, 32'(fd4), 32'd1);
        @(negedge clock);
        chk({tag, "_fd_lo"}, 32'(fd4), 32'd0);
        chk({tag, "_fd_cnt"}, 32'(fd_cnt - base), 32'd1);
    endtask

    task automatic capture_and_check(input string tag, input logic [55:0] exp_v);
        for (int i = 0; i < 8; i++) seen[i] = 7'bx;
        repeat (40) @(posedge clock);
        repeat (32) begin
            @(negedge clock);
            for (int k = 0; k < 8; k++) begin
                if (an4 == ~(8'b1 << k)) seen[k] = seg4;
            end
        end
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("%s_slot%0d", tag, k), 32'(seen[k]), 32'(exp_v[k*7 +: 7]));
        end
    endtask

    task automatic frame_125();
        send(2'b11, 4'd1, 4'd5);
        send(2'b11, 4'd2, 4'd2);
        send(2'b01, 4'd0, 4'd0);
        send(2'b11, 4'd0, 4'd7);
        send(2'b11, 4'd3, 4'd1);
        send(2'b11, 4'd9, 4'd7);
        for (int p = 4; p <= 8; p++) send(2'b11, 4'(p), 4'd0);
    endtask

    initial begin
        int         base;
        logic [7:0] exp_an;

        // reset held for three cycles
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;
        @(negedge clock);
        chk("rst_an", 32'(an4), 32'h000000FE);
        chk("rst_seg", 32'(seg4), 32'h00000040);
        chk("rst_fd", 32'(fd4), 32'd0);
        @(posedge clock);
        #1;

        frame_125();
        commit_frame("f125");
        capture_and_check("f125", {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h24, 7'h12});

        send(2'b11, 4'd1, 4'd7);
        commit_frame("abort7");
        capture_and_check("abort7", {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h78});

        frame_125();
        commit_frame("f125b");

        base = fd_cnt;
        send(2'b00, 4'd0, 4'd0);
        status = 2'b10;
        capture_and_check("err", {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h06, 7'h2F, 7'h2F});
        chk("err_no_fd", 32'(fd_cnt - base), 32'd0);
        @(posedge clock);
        #1;

        send(2'b11, 4'd1, 4'd9);
        commit_frame("f9");
        capture_and_check("f9", {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h10});

        // reset in the middle of a frame
        @(posedge clock);
        #1;
        send(2'b11, 4'd1, 4'd1);
        send(2'b11, 4'd2, 4'd2);
        send(2'b11, 4'd3, 4'd3);
        base  = fd_cnt;
        reset = 1'b0;
        @(posedge clock);
        #1;
        status = 2'b01;
        pos    = 4'd0;
        @(posedge clock);
        #1 reset = 1'b1;
        for (int k = 0; k < 18; k++) begin
            @(negedge clock);
            if (k == 0) begin
                chk("mrst_an4", 32'(an4), 32'h000000FE);
                chk("mrst_seg4", 32'(seg4), 32'h00000040);
            end
            exp_an = ~(8'b1 << ((k / 2) % 8));
            chk($sformatf("scan2_k%0d", k), 32'(an2), 32'(exp_an));
        end
        capture_and_check("mrst", {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40});
        chk("mrst_no_fd", 32'(fd_cnt - base), 32'd0);
        chk("fd_double", 32'(fd_double), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/calc_display.md
# calc_display

Display back end for the calculator core's digit stream. Captures the serialized digit/position/status stream the calculator emits while printing and stores it in a double-buffered 8-digit frame. Drives a time-multiplexed, active-low 8-digit seven-segment display with leading-zero blanking and an "Err" pattern.

## Interface
- DIGITS, 8: number of display digits and frame slots. Slot 0 is the units digit.
- REFRESH_DIV, 50000: clock cycles each digit stays selected during scanning. Must be ≥ 2.
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- status  input  2  calculator status: 00 error, 01 busy, 10 ready, 11 printing.
- data  input  4  BCD digit; valid while status = 11.
- pos  input  4  stream position 1..8; the digit on data belongs to slot pos-1.
- an  output  DIGITS  digit select, active-low, one-hot-low.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
- frame_done  output  1  one-cycle pulse when a captured frame is committed to the display.

## Operation
- Write rule: a write occurs in any cycle with status = 11 and 1 ≤ pos ≤ DIGITS.
  - The write stores data into shadow[pos-1].
  - pos = 0 or pos > DIGITS is ignored.
- Receiver FSM states:
  - IDLE (reset state):
    - status = 11 → CAPTURE. On this transition the shadow buffer is cleared to 0, except the slot written in the same cycle.
    - status = 00 → ERROR.
  - CAPTURE:
    - Writes per the write rule.
    - status = 10 → commit, then IDLE.
    - status = 00 → ERROR, with no commit.
    - status = 01 or 11 → stay in CAPTURE.
  - ERROR:
    - err_flag is set.
    - status = 11 → CAPTURE (shadow cleared as from IDLE).
    - err_flag is cleared only by the next commit or by reset.
- Commit:
  - The display buffer is loaded from shadow.
  - err_flag is cleared.
  - frame_done = 1 for exactly one cycle.
  - A frame aborted early (status 11→10 before slot 7 is written) still commits; unwritten slots read 0.
- Scanner:
  - A free-running divider counts 0..REFRESH_DIV-1.
  - On wrap, the scan index advances 0..DIGITS-1 and wraps to 0.
  - an = all ones except bit[index] = 0.
- Segment encoding, active-low:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - Data values 10..15 display blank (1111111).
- Leading-zero blanking: a slot above the most significant non-zero slot is blank. Slot 0 is never blanked, so value 0 shows a single "0".
- Error display: with err_flag = 1, slot 2 = E (0000110), slots 1 and 0 = r (0101111), all other slots blank. This overrides the display buffer.

## Timing
- Reset (reset = 0), asynchronous:
  - FSM = IDLE; shadow and display buffer = 0; err_flag = 0.
  - Divider and scan index = 0.
  - an = 11111110, seg = 1000000 (shows "0"), frame_done = 0.
- an and seg are registered and update together. seg reflects the slot selected by the current an in the same cycle, with no one-cycle skew.
- Commit latency:
  - The shadow write occurs at the edge ending the status = 11 cycle.
  - The status = 10 cycle causes the commit at its ending edge. frame_done is high in the following cycle.
  - The new value appears on seg at the next scan-index change after the commit, or immediately if the commit coincides with that change.
- Error entry: err_flag is set at the edge ending the first status = 00 cycle. The Err pattern appears under the same rule as a commit.
- Simultaneous events:
  - A write and a state transition in the same cycle both take effect.
  - A scan wrap and a commit in the same cycle: the new index shows new data.
- Reset mid-frame: the partial shadow is discarded and the display returns to "0".
- frame_done never asserts for two consecutive cycles.

## Test plan
- Reset: hold reset = 0 for 3 cycles, then release → an = 11111110, seg = 1000000, frame_done = 0.
- Frame 125:
  - Stimulus: status = 11 with (pos, data) = (1,5), (2,2), (3,1), (4..8, 0); then status = 10, pos = 0.
  - Response: frame_done pulses once; scanning with REFRESH_DIV = 4 shows slot0 = 0010010, slot1 = 0100100, slot2 = 1111001, slots 3..7 = 1111111.
- Aborted frame: status = 11 with (1,7) only, then status = 10 → commit; slot0 = 1111000, all other slots blank.
- Error:
  - Stimulus: status = 00 for 1 cycle after a committed "125".
  - Response: slots 2/1/0 = 0000110/0101111/0101111, others blank. A new frame 9 clears err_flag and shows slot0 = 0010000.
- Reset mid-frame: status = 11, writes at pos 1..3 (data 1,2,3), reset pulsed low → display shows "0" and no frame_done occurs.
- Scan wrap: with REFRESH_DIV = 2, observe 2·DIGITS+2 cycles → an steps 11111110…01111111, then back to 11111110, each step lasting exactly 2 cycles.
